e203_cmd_feeder: RTL
====================

Name: e203_cmd_feeder

Overview:
- Parametrised command sequencer placed between the UART-loaded instruction RAM and the commit core.
- On start, it walks RAM addresses 0..word_count-1. For each word it reads the RAM, issues the word on a valid/ready request channel, then waits for a valid/ready response before moving to the next word.
- Compared with the fixed 4-bit walker it replaces, it adds:
  - programmable word count;
  - loop mode;
  - response timeout with a sticky error flag;
  - abort;
  - progress/status outputs;
  - internal selection of the shared UART tx line.

Parameters:
DW, 32, request data width (RAM word width)
AW, 4, RAM address width; depth = 2**AW
TOW, 16, timeout counter width
TIMEOUT, 16'hFFFF, cycles allowed from req_valid rise to rsp handshake; 0 disables timeout

Ports:
clk  in  1  single clock; RAM read, core handshake and status all in this domain
reset_in  in  1  asynchronous, active-low reset
start  in  1  synchronous 1-cycle pulse; begins a run (ignored unless IDLE/DONE/ERR)
abort  in  1  synchronous pulse; returns to IDLE from any state
loop_en  in  1  sampled at start; 1 = restart at address 0 after the last word
word_count  in  AW+1  number of words per pass, sampled at start; legal range 0..2**AW
rd_en  out  1  RAM read enable
rd_addr  out  AW  RAM read address
rd_data  in  DW  RAM data, valid 1 cycle after rd_en
req_valid  out  1  request valid
req_ready  in  1  request ready from core
req_data  out  DW  request payload, registered
rsp_valid  in  1  response valid from core
rsp_ready  out  1  response ready
tx_uart  in  1  UART loader tx
tx_core  in  1  core tx
tx  out  1  muxed tx: tx_uart in IDLE, tx_core in every other state
busy  out  1  high in READ, CAPT, ISSUE, WAIT_RSP
done  out  1  high in DONE
timeout_err  out  1  high in ERR
words_done  out  16  completed response handshakes since start; saturates at 16'hFFFF

Behaviour:
- Reset values:
  - state = IDLE;
  - rd_en, req_valid, rsp_ready, busy, done, timeout_err = 0;
  - rd_addr = 0; req_data = 0; words_done = 0.
  - tx follows tx_uart during reset.
- States and transitions:
  - IDLE. On start:
    - latch word_count and loop_en; clear words_done and the timeout counter; set rd_addr = 0;
    - go to DONE if the latched count is 0, else go to READ.
  - READ: rd_en = 1 for exactly one cycle at rd_addr; go to CAPT.
  - CAPT: capture rd_data into req_data; set req_valid = 1; go to ISSUE.
    - Total latency from start to first req_valid: 3 cycles.
  - ISSUE:
    - req_valid and req_data are held stable until req_ready = 1.
    - On the handshake cycle: req_valid = 0 next cycle; rsp_ready = 1; go to WAIT_RSP.
  - WAIT_RSP:
    - rsp_ready is held at 1.
    - On rsp_valid = 1: rsp_ready = 0; words_done increments (saturating).
    - If rd_addr == count-1:
      - loop_en = 1: rd_addr = 0, go to READ;
      - loop_en = 0: go to DONE.
    - Otherwise rd_addr increments and the state goes to READ.
    - A rsp_valid arriving while in ISSUE is not accepted (rsp_ready = 0 there).
  - DONE: done = 1. start begins a new run exactly as from IDLE.
  - ERR: timeout_err = 1. req_valid and rsp_ready are 0. Exit only by start (new run) or abort (to IDLE).
- Timeout:
  - The counter runs in ISSUE and WAIT_RSP and is cleared on entry to each READ.
  - When TIMEOUT != 0 and the counter reaches TIMEOUT, the state goes to ERR on the next cycle, dropping req_valid and rsp_ready.
  - A handshake completing in the same cycle as the count reaching TIMEOUT wins: no error is raised.
- Abort:
  - Highest priority, including over start in the same cycle.
  - Next cycle: IDLE, all outputs at their reset values except words_done, which is retained.
  - Dropping req_valid without a handshake is permitted only on abort or timeout.
- Width and boundary rules:
  - word_count = 2**AW: rd_addr wraps from max to 0 only in loop mode; otherwise the run ends after address 2**AW-1.
  - word_count greater than 2**AW: clamped to 2**AW.
  - start while busy: ignored.

Decomposition:
- Shared package e203_feeder_pkg holds:
  - the state encoding constants (IDLE, READ, CAPT, ISSUE, WAIT_RSP, DONE, ERR, 3-bit);
  - the default DW, AW, TOW and TIMEOUT values.
- One natural sub-module: e203_feeder_timeout. It is the TOW-bit counter with clear/enable/expire, which keeps the timeout logic separately testable.
- The tx mux stays inline in e203_cmd_feeder.

Test Plan:
1. word_count=3, loop_en=0, RAM = {A0,A1,A2}, core ready/valid after 2 cycles each:
   - requires req_data A0, A1, A2 in order;
   - done=1 after the third response; words_done=3; rd_addr never exceeds 2.
2. word_count=2, loop_en=1, 5 responses then abort:
   - requires req_data sequence A0, A1, A0, A1, A0;
   - IDLE one cycle after abort; words_done=5.
3. TIMEOUT=8, core never asserts req_ready:
   - req_valid high for 8 cycles with stable req_data;
   - then timeout_err=1 and req_valid=0; a later start restarts at address 0.
4. req_ready tied to 1 and rsp_valid asserted in the same cycle req_valid rises:
   - the response is not taken until WAIT_RSP;
   - exactly one words_done increment per word.
5. word_count=0: start leads to done=1 on the next cycle, with no rd_en and no req_valid.
6. tx mux:
   - tx_uart toggling in IDLE is visible on tx;
   - after start, tx tracks tx_core and ignores tx_uart;
   - in reset, tx follows tx_uart.

Source files
------------

// File: rtl/e203_feeder_pkg.sv
// Shared definitions for the command feeder: state encoding and default
// parameter values used by e203_cmd_feeder and e203_feeder_timeout.
package e203_feeder_pkg;

   localparam int          FEED_DW      = 32;
   localparam int          FEED_AW      = 4;
   localparam int          FEED_TOW     = 16;
   localparam int unsigned FEED_TIMEOUT = 32'h0000_FFFF;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_READ     = 3'd1,
      ST_CAPT     = 3'd2,
      ST_ISSUE    = 3'd3,
      ST_WAIT_RSP = 3'd4,
      ST_DONE     = 3'd5,
      ST_ERR      = 3'd6
   } feed_state_e;

endpackage

// File: rtl/e203_feeder_timeout.sv
// Response timeout counter for the command feeder.
// Ports:
//   clk, reset_in  clock, async active-low reset
//   clr_i          clear the count (held while no transaction is open)
//   en_i           count this cycle (request or response outstanding)
//   expire_o       high in the cycle that completes TIMEOUT counted cycles;
//                  never high when TIMEOUT == 0
// The count saturates at TIMEOUT-1 so that a transaction whose request
// handshake landed exactly on the limit still expires one cycle later if
// the response has not arrived.
module e203_feeder_timeout
   import e203_feeder_pkg::*;
#(
   parameter int          TOW     = FEED_TOW,
   parameter int unsigned TIMEOUT = FEED_TIMEOUT
) (
   input  logic clk,
   input  logic reset_in,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam logic [TOW-1:0] LAST = (TIMEOUT == 0) ? '0 : TOW'(TIMEOUT - 1);

   logic [TOW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && (cnt_q < LAST))
         cnt_d = cnt_q + TOW'(1);
   end

   always_ff @(posedge clk or negedge reset_in) begin
      if (!reset_in) cnt_q <= '0;
      else           cnt_q <= cnt_d;
   end

   assign expire_o = (TIMEOUT != 0) && en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/e203_cmd_feeder.sv
// Command sequencer between the UART-loaded instruction RAM and the commit
// core. On start it walks RAM words 0..count-1: read, issue on the request
// channel, wait for the response, advance. Supports loop mode, abort,
// response timeout and progress/status reporting, and owns the tx mux.
// Ports:
//   clk, reset_in          clock, async active-low reset
//   start, abort, loop_en  run control (abort has top priority)
//   word_count             words per pass, clamped to 2**AW
//   rd_en/rd_addr/rd_data  RAM read port, data one cycle after rd_en
//   req_valid/ready/data   request channel to the core
//   rsp_valid/ready        response channel from the core
//   tx_uart/tx_core/tx     tx mux: loader when idle, core otherwise
//   busy/done/timeout_err  status
//   words_done             saturating response count since start
module e203_cmd_feeder
   import e203_feeder_pkg::*;
#(
   parameter int          DW      = FEED_DW,
   parameter int          AW      = FEED_AW,
   parameter int          TOW     = FEED_TOW,
   parameter int unsigned TIMEOUT = FEED_TIMEOUT
) (
   input  logic          clk,
   input  logic          reset_in,
   input  logic          start,
   input  logic          abort,
   input  logic          loop_en,
   input  logic [AW:0]   word_count,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr,
   input  logic [DW-1:0] rd_data,
   output logic          req_valid,
   input  logic          req_ready,
   output logic [DW-1:0] req_data,
   input  logic          rsp_valid,
   output logic          rsp_ready,
   input  logic          tx_uart,
   input  logic          tx_core,
   output logic          tx,
   output logic          busy,
   output logic          done,
   output logic          timeout_err,
   output logic [15:0]   words_done
);

   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

   feed_state_e   state_q, state_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          loop_q, loop_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic [DW-1:0] req_data_q, req_data_d;
   logic [15:0]   words_q, words_d;

   logic [AW:0]   cnt_in;
   logic          last_word;
   logic          in_txn;
   logic          tmo_expire;

   assign cnt_in    = (word_count > DEPTH) ? DEPTH : word_count;
   // Compared at AW+1 bits so a count of 2**AW ends at address 2**AW-1.
   assign last_word = ({1'b0, rd_addr_q} == (cnt_q - (AW+1)'(1)));
   assign in_txn    = (state_q == ST_ISSUE) || (state_q == ST_WAIT_RSP);

   e203_feeder_timeout #(
      .TOW     (TOW),
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk      (clk),
      .reset_in (reset_in),
      .clr_i    (!in_txn),
      .en_i     (in_txn),
      .expire_o (tmo_expire)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      loop_d     = loop_q;
      rd_addr_d  = rd_addr_q;
      req_data_d = req_data_q;
      words_d    = words_q;

      if (abort) begin
         state_d    = ST_IDLE;
         rd_addr_d  = '0;
         req_data_d = '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (start) begin
                  cnt_d     = cnt_in;
                  loop_d    = loop_en;
                  words_d   = '0;
                  rd_addr_d = '0;
                  state_d   = (cnt_in == '0) ? ST_DONE : ST_READ;
               end
            end
            ST_READ: state_d = ST_CAPT;
            ST_CAPT: begin
               req_data_d = rd_data;
               state_d    = ST_ISSUE;
            end
            ST_ISSUE: begin
               // A handshake on the expiring cycle wins over the timeout.
               if (req_ready)       state_d = ST_WAIT_RSP;
               else if (tmo_expire) state_d = ST_ERR;
            end
            ST_WAIT_RSP: begin
               if (rsp_valid) begin
                  if (words_q != 16'hFFFF) words_d = words_q + 16'd1;
                  if (last_word) begin
                     if (loop_q) begin
                        rd_addr_d = '0;
                        state_d   = ST_READ;
                     end else begin
                        state_d   = ST_DONE;
                     end
                  end else begin
                     rd_addr_d = rd_addr_q + AW'(1);
                     state_d   = ST_READ;
                  end
               end else if (tmo_expire) begin
                  state_d = ST_ERR;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_in) begin
      if (!reset_in) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         loop_q     <= 1'b0;
         rd_addr_q  <= '0;
         req_data_q <= '0;
         words_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         loop_q     <= loop_d;
         rd_addr_q  <= rd_addr_d;
         req_data_q <= req_data_d;
         words_q    <= words_d;
      end
   end

   assign rd_en       = (state_q == ST_READ);
   assign rd_addr     = rd_addr_q;
   assign req_valid   = (state_q == ST_ISSUE);
   assign req_data    = req_data_q;
   assign rsp_ready   = (state_q == ST_WAIT_RSP);
   assign busy        = (state_q == ST_READ) || (state_q == ST_CAPT) || in_txn;
   assign done        = (state_q == ST_DONE);
   assign timeout_err = (state_q == ST_ERR);
   assign words_done  = words_q;

   // Loader owns the line only while idle (reset included).
   assign tx = (state_q == ST_IDLE) ? tx_uart : tx_core;

endmodule
